mic_passcode_detect: RTL and testbench

Clap-pattern passcode detector that sits directly upstream of the OLED passcode display. It consumes 12-bit microphone samples and recognises a burst of exactly `CODE_LEN` claps with legal spacing. On success it raises `micD`, which enables the display stage to draw the passcode. The block holds a small FSM with hysteretic level detection, gap timing, failure counting and an optional lockout.

---
 rtl/mic_passcode_detect.sv | 184 ++++++++++++++++++
 tb/tb_mic_passcode_detect.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_passcode_detect.sv
// Clap-pattern passcode detector: counts hysteretic clap onsets with legal spacing and unlocks micD.
// Optional `PASSCODE_LOCKOUT_EN adds a timed LOCKOUT state after three consecutive failed attempts.
module mic_passcode_detect #(
    parameter logic [11:0] THRESH          = 12'd2500,
    parameter logic [11:0] HYST            = 12'd300,
    parameter logic [15:0] GAP_MIN         = 16'd2000,
    parameter logic [15:0] GAP_MAX         = 16'd20000,
    parameter logic [3:0]  CODE_LEN        = 4'd3,
    parameter logic [19:0] LOCKOUT_SAMPLES = 20'd200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_en,
    input  logic [11:0] mic_in,
    input  logic        sw_clear,
    output logic        micD,
    output logic        clap_pulse,
    output logic [3:0]  clap_cnt,
    output logic [1:0]  fail_cnt
);

    // Release level is THRESH - HYST, clamped to zero when HYST exceeds THRESH.
    localparam logic [12:0] REL_DIFF = {1'b0, THRESH} - {1'b0, HYST};
    localparam logic [11:0] REL_LVL  = REL_DIFF[12] ? 12'd0 : REL_DIFF[11:0];

    if (CODE_LEN == 4'd0 || LOCKOUT_SAMPLES == 20'd0) begin : g_bad_param
        $error("mic_passcode_detect: CODE_LEN and LOCKOUT_SAMPLES must be non-zero");
    end

`ifdef PASSCODE_LOCKOUT_EN
    typedef enum logic [2:0] {
        S_IDLE, S_CLAP_HIGH, S_WAIT_GAP, S_UNLOCKED, S_LOCKOUT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_CLAP_HIGH, S_WAIT_GAP, S_UNLOCKED
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] gap_q, gap_d, gap_inc;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d, fail_sat;
    logic        pulse_q, pulse_d;
    logic        micd_q, micd_d;
    logic        onset, release_lvl, do_fail;
`ifdef PASSCODE_LOCKOUT_EN
    logic [19:0] lock_q, lock_d, lock_inc;
`endif

    assign onset       = (mic_in >= THRESH);
    assign release_lvl = (mic_in < REL_LVL);
    assign gap_inc     = (gap_q == '1) ? gap_q : gap_q + 16'd1;
    assign fail_sat    = (fail_q == 2'd3) ? fail_q : fail_q + 2'd1;
`ifdef PASSCODE_LOCKOUT_EN
    assign lock_inc    = lock_q + 20'd1;
`endif

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        pulse_d = 1'b0;
        do_fail = 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
        lock_d  = lock_q;
`endif
        if (sample_en) begin
            case (state_q)
                S_IDLE: begin
                    if (onset) begin
                        state_d = S_CLAP_HIGH;
                        cnt_d   = 4'd1;
                        pulse_d = 1'b1;
                        gap_d   = '0;
                    end
                end
                S_CLAP_HIGH: begin
                    if (release_lvl) begin
                        state_d = S_WAIT_GAP;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_inc;
                        if (gap_inc >= GAP_MAX) do_fail = 1'b1;
                    end
                end
                S_WAIT_GAP: begin
                    // A qualified onset wins over gap expiry; an early onset is an echo.
                    if (onset && gap_q >= GAP_MIN) begin
                        if (cnt_q >= CODE_LEN) begin
                            do_fail = 1'b1;
                        end else begin
                            state_d = S_CLAP_HIGH;
                            cnt_d   = cnt_q + 4'd1;
                            pulse_d = 1'b1;
                            gap_d   = '0;
                        end
                    end else begin
                        gap_d = gap_inc;
                        if (gap_inc >= GAP_MAX) begin
                            if (cnt_q == CODE_LEN) begin
                                state_d = S_UNLOCKED;
                                fail_d  = '0;
                            end else begin
                                do_fail = 1'b1;
                            end
                        end
                    end
                end
                S_UNLOCKED: ;
`ifdef PASSCODE_LOCKOUT_EN
                S_LOCKOUT: begin
                    if (lock_inc >= LOCKOUT_SAMPLES) begin
                        state_d = S_IDLE;
                        fail_d  = '0;
                        lock_d  = '0;
                    end else begin
                        lock_d = lock_inc;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end

        if (do_fail) begin
            cnt_d   = '0;
            gap_d   = '0;
            fail_d  = fail_sat;
            state_d = S_IDLE;
`ifdef PASSCODE_LOCKOUT_EN
            if (fail_sat == 2'd3) begin
                state_d = S_LOCKOUT;
                lock_d  = '0;
            end
`endif
        end

        if (sw_clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            fail_d  = '0;
            gap_d   = '0;
            pulse_d = 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
            lock_d  = '0;
`endif
        end

        micd_d = (state_d == S_UNLOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
            pulse_q <= 1'b0;
            micd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            pulse_q <= pulse_d;
            micd_q  <= micd_d;
        end
    end

`ifdef PASSCODE_LOCKOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= '0;
        else        lock_q <= lock_d;
    end
`endif

    assign micD       = micd_q;
    assign clap_pulse = pulse_q;
    assign clap_cnt   = cnt_q;
    assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_mic_passcode_detect.sv
// Self-checking bench for mic_passcode_detect: directed scenarios plus randomized clap patterns
// checked against a duration-based reference model. Honours `PASSCODE_LOCKOUT_EN.
module tb_mic_passcode_detect;

    localparam int TH    = 2000;
    localparam int REL   = 1800;
    localparam int GMIN  = 4;
    localparam int GMAX  = 20;
    localparam int CLEN  = 3;
    localparam int LOCKN = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_en = 1'b0;
    logic        sw_clear = 1'b0;
    logic [11:0] mic_in = '0;
    logic        micD, clap_pulse;
    logic [3:0]  clap_cnt;
    logic [1:0]  fail_cnt;
    logic [7:0]  obs;

    mic_passcode_detect #(
        .THRESH(12'd2000), .HYST(12'd200), .GAP_MIN(16'd4), .GAP_MAX(16'd20),
        .CODE_LEN(4'd3), .LOCKOUT_SAMPLES(20'd50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .mic_in(mic_in),
        .sw_clear(sw_clear), .micD(micD), .clap_pulse(clap_pulse),
        .clap_cnt(clap_cnt), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;
    assign obs = {micD, clap_pulse, clap_cnt, fail_cnt};

    int vectors = 0;
    int errors = 0;
    int dut_pulses = 0;

    // Reference model: claps counted, high-run length, quiet-run length, failures, lockout left.
    int m_claps, m_hilen, m_quiet, m_fails, m_lock;
    bit m_unl, m_inclap, m_pulse;

    function automatic void model_clear();
        m_claps = 0; m_hilen = 0; m_quiet = 0; m_fails = 0; m_lock = 0;
        m_unl = 0; m_inclap = 0; m_pulse = 0;
    endfunction

    function automatic void model_fail();
        m_claps = 0;
        m_inclap = 0;
        if (m_fails < 3) m_fails++;
`ifdef PASSCODE_LOCKOUT_EN
        if (m_fails == 3) m_lock = LOCKN;
`endif
    endfunction

    function automatic void model_step(input int mic);
        m_pulse = 0;
        if (m_lock > 0) begin
            m_lock--;
            if (m_lock == 0) m_fails = 0;
            return;
        end
        if (m_unl) return;
        if (m_claps == 0) begin
            if (mic >= TH) begin
                m_claps = 1; m_inclap = 1; m_hilen = 0; m_pulse = 1;
            end
            return;
        end
        if (m_inclap) begin
            if (mic < REL) begin
                m_inclap = 0; m_quiet = 0;
            end else begin
                m_hilen++;
                if (m_hilen == GMAX) model_fail();
            end
            return;
        end
        if (mic >= TH && m_quiet >= GMIN) begin
            if (m_claps == CLEN) model_fail();
            else begin
                m_claps++; m_pulse = 1; m_inclap = 1; m_hilen = 0;
            end
        end else begin
            m_quiet++;
            if (m_quiet == GMAX) begin
                if (m_claps == CLEN) begin
                    m_unl = 1; m_fails = 0;
                end else model_fail();
            end
        end
    endfunction

    function automatic logic [7:0] expv();
        logic [3:0] c;
        logic [1:0] f;
        c = m_claps[3:0];
        f = m_fails[1:0];
        return {m_unl, m_pulse, c, f};
    endfunction

    // One mic sample every 4 clocks; returns 1 time unit after the sampling edge.
    task automatic apply(input int mic, input bit clr = 1'b0);
        repeat (3) @(posedge clk);
        #1;
        mic_in = mic[11:0];
        sample_en = 1'b1;
        sw_clear = clr;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        sw_clear = 1'b0;
        if (clr) model_clear();
        else model_step(mic);
        if (clap_pulse === 1'b1) dut_pulses++;
    endtask

    task automatic clap(input int n);
        repeat (n) apply(3000);
    endtask

    task automatic quiet(input int n);
        repeat (n) apply(0);
    endtask

    task automatic clear();
        apply(0, 1'b1);
    endtask

    task automatic code_ok();
        clap(3); quiet(8); clap(3); quiet(8); clap(3); quiet(21);
    endtask

    task automatic test_reset();
        model_clear();
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", obs, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unlock();
        clear();
        dut_pulses = 0;
        clap(3); quiet(8); clap(3); quiet(8); clap(3); quiet(20);
        vectors++;
        if (obs !== 8'b0_0_0011_00 || obs !== expv()) begin
            errors++;
            $display("FAIL unlock_before_gapmax: got %b want %b", obs, 8'b0_0_0011_00);
        end
        apply(0);
        vectors++;
        if (obs !== 8'b1_0_0011_00 || obs !== expv()) begin
            errors++;
            $display("FAIL unlock_at_gapmax: got %b want %b", obs, 8'b1_0_0011_00);
        end
        vectors++;
        if (dut_pulses !== 3) begin
            errors++;
            $display("FAIL unlock_pulses: got %0d want 3", dut_pulses);
        end
    endtask

    task automatic test_short_code();
        clear();
        clap(3); quiet(8); clap(3); quiet(21);
        vectors++;
        if (obs !== 8'b0_0_0000_01 || obs !== expv()) begin
            errors++;
            $display("FAIL short_code_fail: got %b want %b", obs, 8'b0_0_0000_01);
        end
    endtask

    task automatic test_echo();
        clear();
        dut_pulses = 0;
        clap(3); apply(0); apply(3000);
        vectors++;
        if (obs !== 8'b0_0_0001_00 || obs !== expv()) begin
            errors++;
            $display("FAIL echo_ignored: got %b want %b", obs, 8'b0_0_0001_00);
        end
        quiet(8); clap(3); quiet(8); clap(3); quiet(21);
        vectors++;
        if (obs !== 8'b1_0_0011_00 || dut_pulses !== 3) begin
            errors++;
            $display("FAIL echo_then_unlock: got %b pulses %0d want %b pulses 3", obs, dut_pulses, 8'b1_0_0011_00);
        end
        clear();
        clap(3); quiet(8); clap(3); quiet(8); clap(3); quiet(8); apply(3000);
        vectors++;
        if (obs !== 8'b0_0_0000_01 || obs !== expv()) begin
            errors++;
            $display("FAIL fourth_clap_fails: got %b want %b", obs, 8'b0_0_0000_01);
        end
    endtask

    task automatic test_hysteresis();
        clear();
        apply(3000);
        repeat (19) apply(1900);
        vectors++;
        if (obs !== 8'b0_0_0001_00 || obs !== expv()) begin
            errors++;
            $display("FAIL hyst_hold_high: got %b want %b", obs, 8'b0_0_0001_00);
        end
        apply(1900);
        vectors++;
        if (obs !== 8'b0_0_0000_01 || obs !== expv()) begin
            errors++;
            $display("FAIL hyst_high_timeout: got %b want %b", obs, 8'b0_0_0000_01);
        end
        apply(3000); repeat (3) apply(1900); apply(1799); apply(3000); quiet(4); apply(3000);
        vectors++;
        if (obs !== 8'b0_1_0010_01 || obs !== expv()) begin
            errors++;
            $display("FAIL hyst_release_1799: got %b want %b", obs, 8'b0_1_0010_01);
        end
    endtask

    task automatic test_clear_reset();
        clear();
        code_ok();
        apply(3000, 1'b1);
        vectors++;
        if (obs !== 8'h00 || obs !== expv()) begin
            errors++;
            $display("FAIL sw_clear_unlocked: got %b want %b", obs, 8'h00);
        end
        clap(3); quiet(3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        vectors++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL async_reset_mid_attempt: got %b want %b", obs, 8'h00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_lockout();
        clear();
        repeat (3) begin
            clap(1); quiet(21);
        end
        vectors++;
        if (obs !== 8'b0_0_0000_11 || obs !== expv()) begin
            errors++;
            $display("FAIL three_fails: got %b want %b", obs, 8'b0_0_0000_11);
        end
        dut_pulses = 0;
        clap(3); quiet(8); clap(3); quiet(8); clap(3);
`ifdef PASSCODE_LOCKOUT_EN
        vectors++;
        if (dut_pulses !== 0 || obs !== expv()) begin
            errors++;
            $display("FAIL lockout_ignores_mic: got pulses %0d obs %b want pulses 0 obs %b", dut_pulses, obs, expv());
        end
        quiet(25);
        vectors++;
        if (obs !== 8'b0_0_0000_00 || obs !== expv()) begin
            errors++;
            $display("FAIL lockout_expiry: got %b want %b", obs, 8'b0_0_0000_00);
        end
        code_ok();
`else
        vectors++;
        if (dut_pulses !== 3) begin
            errors++;
            $display("FAIL no_lockout_pulses: got %0d want 3", dut_pulses);
        end
        quiet(21);
`endif
        vectors++;
        if (obs !== 8'b1_0_0011_00 || obs !== expv()) begin
            errors++;
            $display("FAIL unlock_after_fails: got %b want %b", obs, 8'b1_0_0011_00);
        end
    endtask

    task automatic test_random();
        int hv[6] = '{2000, 2001, 3000, 4095, 1800, 1999};
        int lv[3] = '{0, 1799, 1000};
        int v;
        clear();
        for (int seg = 0; seg < 120; seg++) begin
            if ($urandom_range(0, 9) == 0) begin
                apply(int'($urandom_range(0, 4095)), 1'b1);
                vectors++;
                if (obs !== expv()) begin
                    errors++;
                    $display("FAIL random_clear seg %0d: got %b want %b", seg, obs, expv());
                end
            end
            for (int h = 0, nh = $urandom_range(1, 4); h < nh; h++) begin
                v = ($urandom_range(0, 1) == 0) ? hv[$urandom_range(0, 5)] : int'($urandom_range(1800, 4095));
                apply(v);
                vectors++;
                if (obs !== expv()) begin
                    errors++;
                    $display("FAIL random_high seg %0d mic %0d: got %b want %b", seg, v, obs, expv());
                end
            end
            for (int l = 0, nl = $urandom_range(0, 24); l < nl; l++) begin
                v = ($urandom_range(0, 1) == 0) ? lv[$urandom_range(0, 2)] : int'($urandom_range(0, 1799));
                apply(v);
                vectors++;
                if (obs !== expv()) begin
                    errors++;
                    $display("FAIL random_low seg %0d mic %0d: got %b want %b", seg, v, obs, expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_short_code();
        test_echo();
        test_hysteresis();
        test_clear_reset();
        test_lockout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
